cpu_run_monitor: RTL
====================

Name: cpu_run_monitor

Overview:
- Synthesizable run controller and trace monitor for the single-cycle MIPS core (mipsCPUData-class top).
- Gates the CPU with a clock enable and drives its reset.
- Ends a run on halt instruction, PC stall or cycle timeout.
- Captures register-file writes into a trace FIFO that the bench or a debug port drains, replacing fixed-count clock loops.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, register write-data width
- RADDR_W, 5, register address width
- MAX_CYCLES, 130, maximum CPU-enabled cycles per run (>=1)
- STALL_LIMIT, 4, consecutive cycles with unchanged PC that end the run (>=2)
- HALT_INSTR, 32'hFC000000, instruction word that ends the run
- TRACE_DEPTH, 16, trace FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- start  in  1  begin a run (sampled in IDLE or DONE)
- abort  in  1  stop the run immediately, return to IDLE
- pc  in  ADDR_W  current CPU program counter
- instr  in  32  current fetched instruction
- reg_wr_en  in  1  CPU register-file write strobe
- reg_wr_addr  in  RADDR_W  CPU write register number
- reg_wr_data  in  DATA_W  CPU write data
- cpu_en  out  1  CPU clock enable
- cpu_rst  out  1  CPU reset
- running  out  1  high in RUN
- done  out  1  high in DONE
- done_cause  out  2  0 none/abort, 1 halt, 2 stall, 3 timeout
- cycle_count  out  32  CPU-enabled cycles in current/last run
- trace_rd_en  in  1  pop trace head
- trace_rd_data  out  RADDR_W+DATA_W  head entry {addr, data}, show-ahead
- trace_empty  out  1  FIFO empty
- trace_count  out  $clog2(TRACE_DEPTH)+1  entries held
- trace_ovf  out  1  sticky: a write was dropped because FIFO full

Behaviour:
- Reset: state=IDLE, cpu_en=0, cpu_rst=1, running=0, done=0, done_cause=0, cycle_count=0, FIFO empty, trace_ovf=0, stall counter=0, prev_pc=0. Reset overrides all inputs, including mid-run.
- IDLE: cpu_en=0, cpu_rst=1. start -> RUN next cycle; same edge clears cycle_count, stall counter, FIFO, trace_ovf, done_cause.
- RUN: cpu_rst=0, cpu_en=1 combinationally from state; cycle_count+1 per RUN cycle.
- Stall counter: reset to 1 on the first RUN cycle. Afterwards, +1 when pc==prev_pc, else set to 1. prev_pc is registered every RUN cycle.
- Exit checks are evaluated on the current-cycle values; exit takes effect next edge. Priority: abort > halt > stall > timeout.
  - abort -> IDLE, cause 0.
  - instr==HALT_INSTR -> DONE, cause 1.
  - stall counter==STALL_LIMIT-1 and pc==prev_pc -> DONE, cause 2.
  - cycle_count==MAX_CYCLES-1 -> DONE, cause 3 (exactly MAX_CYCLES enabled cycles).
- The terminating cycle is itself an enabled cycle and is counted.
- DONE: cpu_en=0, cpu_rst=0 (CPU state held for inspection), done=1. cycle_count and done_cause hold. start -> RUN with the same clears as from IDLE. abort -> IDLE.
- start in RUN is ignored. abort in IDLE or DONE moves to or stays in IDLE; cause cleared.
- Trace push condition: RUN && reg_wr_en && reg_wr_addr!=0. Pushes {reg_wr_addr, reg_wr_data}. The terminating cycle's write is captured.
- Full FIFO: a push is dropped and trace_ovf set; an existing entry is never overwritten. Simultaneous push+pop when full: both occur, count unchanged, no overflow.
- Pop: trace_rd_en && !trace_empty advances the head. Pop when empty is ignored with no error. Reads are legal in any state.
- Pointers wrap modulo TRACE_DEPTH. trace_count is 0..TRACE_DEPTH.
- trace_rd_data is undefined-but-stable when empty; the bench must not check it.

Decomposition:
- Shared package/header cpu_dbg_defs:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - cause codes CAUSE_NONE/HALT/STALL/TIMEOUT
  - default HALT_INSTR
- One sub-module: trace_fifo.
  - Parametrised WIDTH and DEPTH.
  - Ports: clk, reset, clear, push, din, pop, dout, empty, full, count, ovf.
  - Implements the full/empty/simultaneous rules above.
- cpu_run_monitor holds the FSM, counters and exit logic.

Test Plan:
- Reset mid-run: start, run 5 cycles, assert reset -> next edge cpu_en=0, cpu_rst=1, cycle_count=0, trace_empty=1, done=0.
- Timeout: MAX_CYCLES=130, pc incrementing by 4, no halt -> done after exactly 130 enabled cycles, cycle_count=130, done_cause=3.
- Halt: instr=32'hFC000000 on the 7th RUN cycle -> done_cause=1, cycle_count=7, cpu_en low from the 8th edge.
- Stall: pc held at 32'h20 from cycle 3 with STALL_LIMIT=4 -> done_cause=2, cycle_count=6. The same cycle also hitting timeout still reports cause 2.
- Trace overflow:
  - 20 writes to $1..$20 with TRACE_DEPTH=16 -> trace_count=16, trace_ovf=1.
  - Pops return {1,d1}..{16,d16} in order.
  - Writes to $0 never appear.
- Full push+pop and restart:
  - FIFO full, push and pop same cycle -> count stays 16, ovf stays 0.
  - start from DONE -> FIFO cleared, ovf=0, cycle_count restarts from 0.

Source files
------------

// File: rtl/cpu_dbg_defs.sv
// Shared definitions for the CPU run monitor: FSM states,
// run-end cause codes and the default halt instruction word.
package cpu_dbg_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_HALT    = 2'd1,
      CAUSE_STALL   = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_t;

   localparam logic [31:0] HALT_INSTR_DEF = 32'hFC00_0000;

endpackage

// File: rtl/trace_fifo.sv
// Register-write trace FIFO, show-ahead head, sticky overflow.
// Ports: clk/reset, clear, push/din, pop/dout, empty, full, count, ovf.
module trace_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and register-write trace monitor for a single-cycle CPU.
// Ports: clk/reset, start/abort, CPU pc/instr/reg-write taps,
// cpu_en/cpu_rst, status (running/done/cause/cycles), trace read port.
module cpu_run_monitor
   import cpu_dbg_defs::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 32,
   parameter int          RADDR_W     = 5,
   parameter int          MAX_CYCLES  = 130,
   parameter int          STALL_LIMIT = 4,
   parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF,
   parameter int          TRACE_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic [ADDR_W-1:0]              pc,
   input  logic [31:0]                    instr,
   input  logic                           reg_wr_en,
   input  logic [RADDR_W-1:0]             reg_wr_addr,
   input  logic [DATA_W-1:0]              reg_wr_data,
   output logic                           cpu_en,
   output logic                           cpu_rst,
   output logic                           running,
   output logic                           done,
   output logic [1:0]                     done_cause,
   output logic [31:0]                    cycle_count,
   input  logic                           trace_rd_en,
   output logic [RADDR_W+DATA_W-1:0]      trace_rd_data,
   output logic                           trace_empty,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   output logic                           trace_ovf
);

   localparam logic [31:0] STALL_LAST = 32'(STALL_LIMIT - 1);
   localparam logic [31:0] TIME_LAST  = 32'(MAX_CYCLES - 1);

   state_t             state;
   cause_t             cause;
   logic [31:0]        stall_cnt;
   logic [ADDR_W-1:0]  prev_pc;

   logic run;
   logic first;
   logic pc_same;
   logic hit_halt;
   logic hit_stall;
   logic hit_time;
   logic launch;
   logic push;
   logic full_unused;

   assign run       = (state == ST_RUN);
   assign first     = (cycle_count == '0);
   assign pc_same   = (pc == prev_pc);
   assign hit_halt  = (instr == HALT_INSTR);
   assign hit_stall = (stall_cnt == STALL_LAST) && pc_same;
   assign hit_time  = (cycle_count == TIME_LAST);
   assign launch    = start && !abort && !run;
   assign push      = run && reg_wr_en && (reg_wr_addr != '0);

   assign cpu_en     = run;
   assign cpu_rst    = (state == ST_IDLE);
   assign running    = run;
   assign done       = (state == ST_DONE);
   assign done_cause = cause;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cause       <= CAUSE_NONE;
         cycle_count <= '0;
         stall_cnt   <= '0;
         prev_pc     <= '0;
      end else begin
         unique case (state)
            ST_RUN: begin
               cycle_count <= cycle_count + 1'b1;
               prev_pc     <= pc;
               // prev_pc is stale on the first cycle of a run
               if (first || !pc_same) stall_cnt <= 32'd1;
               else                   stall_cnt <= stall_cnt + 1'b1;
               if (abort) begin
                  state <= ST_IDLE;
                  cause <= CAUSE_NONE;
               end else if (hit_halt) begin
                  state <= ST_DONE;
                  cause <= CAUSE_HALT;
               end else if (hit_stall) begin
                  state <= ST_DONE;
                  cause <= CAUSE_STALL;
               end else if (hit_time) begin
                  state <= ST_DONE;
                  cause <= CAUSE_TIMEOUT;
               end
            end
            default: begin
               if (abort) begin
                  state <= ST_IDLE;
                  cause <= CAUSE_NONE;
               end else if (launch) begin
                  state       <= ST_RUN;
                  cause       <= CAUSE_NONE;
                  cycle_count <= '0;
                  stall_cnt   <= '0;
               end
            end
         endcase
      end
   end

   trace_fifo #(
      .WIDTH (RADDR_W + DATA_W),
      .DEPTH (TRACE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (launch),
      .push  (push),
      .din   ({reg_wr_addr, reg_wr_data}),
      .pop   (trace_rd_en),
      .dout  (trace_rd_data),
      .empty (trace_empty),
      .full  (full_unused),
      .count (trace_count),
      .ovf   (trace_ovf)
   );

endmodule
